countdown_timer: RTL and testbench

- Countdown timer feeding the timer slot (mode 2) of the clock top level.
- Consumes the four debounced buttons routed in timer mode:
  - BTNC → start_i (start/pause/increment)
  - BTND → edit_i
  - BTNL → left_i
  - BTNR → right_i
- Produces the 36-bit packed digit word shown by the VGA renderer, plus edit-cursor and expiry status.
- Runs on the 1 kHz divided clock.

---
 rtl/countdown_timer.sv | 214 +++++++++++++++++++++
 tb/tb_countdown_timer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Countdown timer for the clock's timer slot: edit/run/pause/expire over a packed HH:MM:SS digit word.
// Define COUNTDOWN_ALARM_BLINK_EN to make alarm_o blink while expired instead of following done_o.
module countdown_timer #(
  parameter int          CLK_FREQ_HZ = 1000,
  parameter logic [35:0] PRESET      = 36'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        edit_i,
  input  logic        left_i,
  input  logic        right_i,
  output logic [35:0] out_o,
  output logic        edit_o,
  output logic [2:0]  digit_o,
  output logic        running_o,
  output logic        done_o,
  output logic        alarm_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT    = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } state_e;

  localparam int            PW       = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ_HZ - 1);

  state_e        state_q, state_d;
  logic [35:0]   count_q, count_d;
  logic [35:0]   preset_q, preset_d;
  logic [2:0]    cursor_q, cursor_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    btn_q;
  logic          edit_q, running_q, done_q;

  logic [3:0]    btn;
  logic [3:0]    rise;
  logic          ev_start, ev_edit, ev_left, ev_right;
  logic [35:0]   count_dec;

  // Field 1 (S tens) and field 3 (M tens) hold 0-5, the rest 0-9.
  function automatic logic [5:0] field_max(input int idx);
    return (idx == 1 || idx == 3) ? 6'd5 : 6'd9;
  endfunction

  function automatic logic [35:0] incr_field(input logic [35:0] c, input logic [2:0] sel);
    logic [35:0] r;
    logic [5:0]  f;
    r = c;
    for (int i = 0; i < 6; i++) begin
      f = c[i*6 +: 6];
      if (sel == 3'(i)) r[i*6 +: 6] = (f >= field_max(i)) ? 6'd0 : f + 6'd1;
    end
    return r;
  endfunction

  function automatic logic [35:0] decr_count(input logic [35:0] c);
    logic [35:0] r;
    logic [5:0]  f;
    logic        borrow;
    r      = c;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f = c[i*6 +: 6];
      if (borrow) begin
        if (f == 6'd0) begin
          r[i*6 +: 6] = field_max(i);
        end else begin
          r[i*6 +: 6] = f - 6'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Edges are decoded against last cycle's sample; priority edit > start > left > right.
  assign btn       = {right_i, left_i, edit_i, start_i};
  assign rise      = btn & ~btn_q;
  assign ev_edit   = rise[1];
  assign ev_start  = rise[0] & ~rise[1];
  assign ev_left   = rise[2] & ~rise[1] & ~rise[0];
  assign ev_right  = rise[3] & ~rise[2] & ~rise[1] & ~rise[0];
  assign count_dec = decr_count(count_q);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    cursor_d = cursor_q;
    presc_d  = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_edit) begin
          state_d = ST_EDIT;
        end else if (ev_start && count_q != '0) begin
          state_d = ST_RUNNING;
          presc_d = '0;
        end
      end
      ST_EDIT: begin
        if (ev_edit) begin
          preset_d = count_q;
          state_d  = ST_IDLE;
        end else if (ev_start) begin
          count_d = incr_field(count_q, cursor_q);
        end else if (ev_left) begin
          cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
        end else if (ev_right) begin
          cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
        end
      end
      ST_RUNNING: begin
        if (ev_start) begin
          state_d = ST_PAUSED;
        end else if (presc_q == PRESC_TC) begin
          presc_d = '0;
          count_d = count_dec;
          if (count_dec == '0) state_d = ST_EXPIRED;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSED: begin
        if (ev_edit) begin
          state_d = ST_EDIT;
        end else if (ev_start) begin
          state_d = ST_RUNNING;
        end
      end
      ST_EXPIRED: begin
        count_d = '0;
        if (ev_edit || ev_start) begin
          state_d = ST_IDLE;
          count_d = preset_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      count_q   <= PRESET;
      preset_q  <= PRESET;
      cursor_q  <= 3'd0;
      presc_q   <= '0;
      btn_q     <= 4'd0;
      edit_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      preset_q  <= preset_d;
      cursor_q  <= cursor_d;
      presc_q   <= presc_d;
      btn_q     <= btn;
      edit_q    <= (state_d == ST_EDIT);
      running_q <= (state_d == ST_RUNNING);
      done_q    <= (state_d == ST_EXPIRED);
    end
  end

`ifdef COUNTDOWN_ALARM_BLINK_EN
  localparam int HALF = (CLK_FREQ_HZ / 2 > 0) ? CLK_FREQ_HZ / 2 : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          alarm_q, alarm_d;

  // Starts high on entry to EXPIRED, then flips every HALF cycles while expired.
  always_comb begin
    blink_cnt_d = '0;
    alarm_d     = 1'b0;
    if (state_d == ST_EXPIRED) begin
      if (state_q != ST_EXPIRED) begin
        alarm_d = 1'b1;
      end else if (blink_cnt_q == BW'(HALF - 1)) begin
        alarm_d = ~alarm_q;
      end else begin
        alarm_d     = alarm_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      blink_cnt_q <= '0;
      alarm_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      alarm_q     <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;
`else
  assign alarm_o = done_q;
`endif

  assign out_o     = count_q;
  assign edit_o    = edit_q;
  assign digit_o   = cursor_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at CLK_FREQ_HZ=4 with a 00:00:05 preset.
module tb_countdown_timer;

  localparam int          FREQ      = 4;
  localparam logic [35:0] TB_PRESET = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5};
  localparam int B_START = 0, B_EDIT = 1, B_LEFT = 2, B_RIGHT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_edit, btn_left, btn_right;
  logic [35:0] out_w;
  logic        edit_w, running_w, done_w, alarm_w;
  logic [2:0]  digit_w;

  int tests_run    = 0;
  int tests_failed = 0;

  countdown_timer #(.CLK_FREQ_HZ(FREQ), .PRESET(TB_PRESET)) dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .start_i  (btn_start),
    .edit_i   (btn_edit),
    .left_i   (btn_left),
    .right_i  (btn_right),
    .out_o    (out_w),
    .edit_o   (edit_w),
    .digit_o  (digit_w),
    .running_o(running_w),
    .done_o   (done_w),
    .alarm_o  (alarm_w)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] hms(input int h, input int m, input int s);
    return {6'(h / 10), 6'(h % 10), 6'(m / 10), 6'(m % 10), 6'(s / 10), 6'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press followed by one released cycle; called and returns at a negedge.
  task automatic pulse(input int which);
    case (which)
      B_START: btn_start = 1'b1;
      B_EDIT:  btn_edit  = 1'b1;
      B_LEFT:  btn_left  = 1'b1;
      default: btn_right = 1'b1;
    endcase
    @(negedge clk);
    btn_start = 1'b0;
    btn_edit  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_n(input int which, input int n);
    for (int k = 0; k < n; k++) pulse(which);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_alarm_mid;
`ifdef COUNTDOWN_ALARM_BLINK_EN
    exp_alarm_mid = 1'b0;
`else
    exp_alarm_mid = 1'b1;
`endif
    rst = 1'b1;
    btn_start = 1'b0; btn_edit = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);

    // Reset state
    check("rst_out",     out_w,            TB_PRESET);
    check("rst_edit",    36'(edit_w),      36'd0);
    check("rst_running", 36'(running_w),   36'd0);
    check("rst_done",    36'(done_w),      36'd0);
    check("rst_alarm",   36'(alarm_w),     36'd0);
    check("rst_digit",   36'(digit_w),     36'd0);

    // Edit: S ones 5 -> 8, cursor wraps to S tens, S tens wraps after 6 presses
    pulse(B_EDIT);
    check("edit_enter", 36'(edit_w), 36'd1);
    pulse_n(B_START, 3);
    check("edit_sones", out_w, hms(0, 0, 8));
    pulse_n(B_RIGHT, 5);
    check("edit_cursor_wrap", 36'(digit_w), 36'd1);
    pulse_n(B_START, 5);
    check("edit_stens5", out_w, hms(0, 0, 58));
    pulse(B_START);
    check("edit_stens_wrap", out_w, hms(0, 0, 8));
    pulse(B_EDIT);
    check("edit_exit", 36'(edit_w), 36'd0);
    check("edit_exit_out", out_w, hms(0, 0, 8));

    // Build 00:01:00
    pulse(B_EDIT);
    pulse(B_RIGHT);
    pulse_n(B_START, 2);
    check("sones_9_wrap", out_w, hms(0, 0, 0));
    pulse_n(B_LEFT, 2);
    pulse(B_START);
    pulse(B_EDIT);
    check("set_1min", out_w, hms(0, 1, 0));
    check("set_1min_digit", 36'(digit_w), 36'd2);

    // Run: decrement every 4 cycles with borrow from minutes
    pulse(B_START);
    check("run_running", 36'(running_w), 36'd1);
    wait_cycles(2);
    check("run_before_tick", out_w, hms(0, 1, 0));
    wait_cycles(1);
    check("run_tick1", out_w, hms(0, 0, 59));
    wait_cycles(3);
    check("run_before_tick2", out_w, hms(0, 0, 59));
    wait_cycles(1);
    check("run_tick2", out_w, hms(0, 0, 58));

    // Pause with prescaler at 1; resume decrements after the remaining 3 cycles
    wait_cycles(1);
    pulse(B_START);
    check("pause_running", 36'(running_w), 36'd0);
    wait_cycles(20);
    check("pause_hold", out_w, hms(0, 0, 58));
    pulse(B_START);
    check("resume_running", 36'(running_w), 36'd1);
    wait_cycles(1);
    check("resume_before_tick", out_w, hms(0, 0, 58));
    wait_cycles(1);
    check("resume_tick", out_w, hms(0, 0, 57));

    // Asynchronous reset mid-run
    wait_cycles(1);
    #2 rst = 1'b1;
    #1 check("async_rst_out", out_w, TB_PRESET);
    check("async_rst_running", 36'(running_w), 36'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out", out_w, TB_PRESET);
    check("post_rst_digit", 36'(digit_w), 36'd0);
    check("post_rst_running", 36'(running_w), 36'd0);

    // Expiry from 00:00:02, alarm behaviour, restore of preset
    pulse(B_EDIT);
    pulse_n(B_START, 7);
    pulse(B_EDIT);
    check("set_2s", out_w, hms(0, 0, 2));
    pulse(B_START);
    wait_cycles(6);
    check("exp_before_out", out_w, hms(0, 0, 1));
    check("exp_before_done", 36'(done_w), 36'd0);
    wait_cycles(1);
    check("exp_out", out_w, 36'd0);
    check("exp_done", 36'(done_w), 36'd1);
    check("exp_running", 36'(running_w), 36'd0);
    check("exp_alarm_entry", 36'(alarm_w), 36'd1);
    wait_cycles(1);
    check("exp_alarm_c1", 36'(alarm_w), 36'd1);
    wait_cycles(1);
    check("exp_alarm_c2", 36'(alarm_w), 36'(exp_alarm_mid));
    wait_cycles(2);
    check("exp_alarm_c4", 36'(alarm_w), 36'd1);
    check("exp_hold_zero", out_w, 36'd0);
    pulse(B_START);
    check("restore_out", out_w, hms(0, 0, 2));
    check("restore_done", 36'(done_w), 36'd0);
    check("restore_alarm", 36'(alarm_w), 36'd0);
    check("restore_running", 36'(running_w), 36'd0);

    // A held button yields a single event
    btn_edit = 1'b1;
    wait_cycles(5);
    btn_edit = 1'b0;
    wait_cycles(1);
    check("held_edit", 36'(edit_w), 36'd1);
    pulse(B_EDIT);
    check("held_edit_exit", 36'(edit_w), 36'd0);

    // Simultaneous edit+start in IDLE: edit wins, start dropped
    btn_edit  = 1'b1;
    btn_start = 1'b1;
    @(negedge clk);
    btn_edit  = 1'b0;
    btn_start = 1'b0;
    @(negedge clk);
    check("both_edit", 36'(edit_w), 36'd1);
    check("both_running", 36'(running_w), 36'd0);
    check("both_out", out_w, hms(0, 0, 2));

    // Start with zero count in IDLE is ignored
    pulse_n(B_START, 8);
    check("set_zero", out_w, 36'd0);
    pulse(B_EDIT);
    pulse(B_START);
    check("zero_start_running", 36'(running_w), 36'd0);
    check("zero_start_done", 36'(done_w), 36'd0);

    // Cursor wraps both ways; H tens wraps 9 -> 0
    pulse(B_EDIT);
    pulse_n(B_LEFT, 5);
    check("cursor_left5", 36'(digit_w), 36'd5);
    pulse(B_LEFT);
    check("cursor_left_wrap", 36'(digit_w), 36'd0);
    pulse(B_RIGHT);
    check("cursor_right_wrap", 36'(digit_w), 36'd5);
    pulse_n(B_START, 9);
    check("htens_9", out_w, hms(90, 0, 0));
    pulse(B_START);
    check("htens_wrap", out_w, 36'd0);
    pulse(B_RIGHT);
    pulse(B_START);
    pulse(B_EDIT);
    check("set_1h", out_w, hms(1, 0, 0));

    // Full borrow chain 01:00:00 -> 00:59:59, then pause and edit keep the count
    pulse(B_START);
    wait_cycles(2);
    check("hour_before_tick", out_w, hms(1, 0, 0));
    wait_cycles(1);
    check("hour_borrow", out_w, hms(0, 59, 59));
    pulse(B_START);
    pulse(B_EDIT);
    check("pause_edit_mode", 36'(edit_w), 36'd1);
    check("pause_edit_out", out_w, hms(0, 59, 59));
    check("pause_edit_digit", 36'(digit_w), 36'd4);
    check("pause_edit_running", 36'(running_w), 36'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
